// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus state encoding and default source indices
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRIVE    = 2'd1,
        CONFLICT = 2'd2
    } bus_state_t;

    localparam int SRC_R0      = 0;
    localparam int SRC_R1      = 1;
    localparam int SRC_R2      = 2;
    localparam int SRC_R3      = 3;
    localparam int SRC_R4      = 4;
    localparam int SRC_R5      = 5;
    localparam int SRC_R6      = 6;
    localparam int SRC_R7      = 7;
    localparam int SRC_R8      = 8;
    localparam int SRC_R9      = 9;
    localparam int SRC_R10     = 10;
    localparam int SRC_R11     = 11;
    localparam int SRC_R12     = 12;
    localparam int SRC_R13     = 13;
    localparam int SRC_R14     = 14;
    localparam int SRC_R15     = 15;
    localparam int SRC_HI      = 16;
    localparam int SRC_LO      = 17;
    localparam int SRC_ZHI     = 18;
    localparam int SRC_ZLO     = 19;
    localparam int SRC_PC      = 20;
    localparam int SRC_MDR     = 21;
    localparam int SRC_INPORT  = 22;
    localparam int SRC_CSIGN   = 23;
    localparam int BUS_NUM_SRC = 24;

endpackage

// File: rtl/onehot_encoder.sv
// rtl/onehot_encoder.sv - lowest-set-bit index encoder with zero and multi-hot flags
module onehot_encoder #(
    parameter int N     = 24,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             zero,
    output logic             multi
);

    // Scan from the top down so the lowest set bit is written last and wins.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign zero  = (vec == '0);
    // Clearing the lowest set bit leaves something only when two or more were set.
    assign multi = ((vec & (vec - N'(1))) != '0);

endmodule

// File: rtl/bus_mux_reg.sv
// rtl/bus_mux_reg.sv - registered one-hot bus multiplexer with sticky conflict detection
module bus_mux_reg
    import bus_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               NUM_SRC   = BUS_NUM_SRC,
    parameter int               SEL_W     = $clog2(NUM_SRC),
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_out,
    input  logic                     bus_en,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         bus_out,
    output logic                     bus_valid,
    output logic [SEL_W-1:0]         sel_idx,
    output logic [1:0]               bus_state,
    output logic                     conflict
);

    logic [SEL_W-1:0] enc_idx;
    logic             enc_zero;
    logic             enc_multi;
    logic [WIDTH-1:0] mux_word;
    bus_state_t       state;

    onehot_encoder #(
        .N     (NUM_SRC),
        .IDX_W (SEL_W)
    ) u_enc (
        .vec   (src_out),
        .idx   (enc_idx),
        .zero  (enc_zero),
        .multi (enc_multi)
    );

    // AND-OR mux keyed directly by the one-hot enables; only consumed when
    // exactly one enable is set, so the OR never merges two words.
    always_comb begin
        mux_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_out[i]) begin
                mux_word = mux_word | src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bus_out   <= RESET_VAL;
            bus_valid <= 1'b0;
            sel_idx   <= '0;
            state     <= IDLE;
            conflict  <= 1'b0;
        end else begin
            if (bus_en) begin
                if (enc_zero) begin
                    state     <= IDLE;
                    bus_valid <= 1'b0;
                end else if (enc_multi) begin
                    state     <= CONFLICT;
                    bus_valid <= 1'b0;
                end else begin
                    state     <= DRIVE;
                    bus_valid <= 1'b1;
                    bus_out   <= mux_word;
                    sel_idx   <= enc_idx;
                end
            end
            // A new conflict outranks a clear on the same edge.
            if (bus_en && enc_multi) begin
                conflict <= 1'b1;
            end else if (err_clr) begin
                conflict <= 1'b0;
            end
        end
    end

    assign bus_state = state;

endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
- Parametrised, registered successor to the datapath bus multiplexer.
- Selects one of NUM_SRC source words onto a shared WIDTH-bit bus using one-hot "out" enables from the control unit. The block encodes those enables internally.
- The bus value is registered and holds the last driven value when nothing drives it. A multi-driver conflict is detected, reported and made sticky.
- Sits between the register file/special registers (HI, LO, Z, PC, MDR, InPort, C) and all bus consumers.

Parameters:
- WIDTH, 32, bus/source word width in bits.
- NUM_SRC, 24, number of bus sources (index 0..NUM_SRC-1); must be >= 2.
- SEL_W, $clog2(NUM_SRC), width of the encoded select index (5 at default).
- RESET_VAL, 0, value loaded into bus_out on reset.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-low reset.
- src_data  input  NUM_SRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- src_out  input  NUM_SRC  one-hot drive enables; bit i = source i requests the bus.
- bus_en  input  1  bus update enable; 0 freezes bus and state (enables ignored).
- err_clr  input  1  synchronous clear of the sticky conflict flag.
- bus_out  output  WIDTH  registered bus value.
- bus_valid  output  1  1 = bus_out was loaded from a single driver on the previous enabled cycle.
- sel_idx  output  SEL_W  registered index of the last successful driver.
- bus_state  output  2  FSM state: 0 IDLE, 1 DRIVE, 2 CONFLICT.
- conflict  output  1  sticky: at least one multi-driver cycle since the last clear.

Behaviour:
- Reset (clr=0, asynchronous): bus_out=RESET_VAL, bus_valid=0, sel_idx=0, bus_state=IDLE, conflict=0.
- Latency: 1 cycle. Enables and data sampled at edge N appear on bus_out after edge N. No combinational path from src_* to outputs.
- Drive count per cycle, cnt = popcount(src_out), classified as 0, 1 or >1.
- FSM transitions, evaluated each edge with bus_en=1:
  - cnt==0 -> IDLE: bus_out and sel_idx hold, bus_valid=0.
  - cnt==1 -> DRIVE: bus_out=src_data[k], sel_idx=k, bus_valid=1.
  - cnt>1 -> CONFLICT: bus_out and sel_idx hold, bus_valid=0, conflict set.
- Any state may go to any state; the next state depends only on the current cnt.
- bus_en=0: all registers hold, including bus_state and bus_valid. err_clr still acts.
- Sticky flag: conflict is cleared by err_clr=1 at an edge. If err_clr=1 coincides with a CONFLICT-classified edge, set wins and conflict=1.
- Indices >= NUM_SRC do not exist. The hold-on-undefined behaviour is replaced by the explicit IDLE hold.
- Mid-operation reset returns all outputs to reset values immediately, regardless of clk.
- The source word is passed through unchanged: no sign or zero extension inside the block.

Decomposition:
- Package bus_pkg holds:
  - bus_state_t enum: IDLE=2'd0, DRIVE=2'd1, CONFLICT=2'd2.
  - Default source-index constants: SRC_R0..SRC_R15=0..15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_CSIGN=23, BUS_NUM_SRC=24.
- Sub-module onehot_encoder (parameter N), purely combinational:
  - Outputs idx (lowest set bit).
  - Outputs zero (no bit set).
  - Outputs multi (>1 bit set).
- The top-level module instantiates onehot_encoder and contains the data mux, registers and FSM.

Test Plan:
- Reset: clr=0 with src_out=1<<5 toggling -> bus_out=0, bus_valid=0, bus_state=0, conflict=0 throughout. Release clr, drive src_out=1<<5 with R5=0xDEADBEEF -> after one edge bus_out=0xDEADBEEF, sel_idx=5, bus_state=1.
- Sweep: for i=0..23 set src_out=1<<i, source i = 0xA5000000|i -> next cycle bus_out matches and sel_idx=i. Include i=23 (C_sign_extended) and i=20 (PC).
- Hold: drive MDR (21) = 0x12345678 one cycle, then src_out=0 for 3 cycles -> bus_out stays 0x12345678, bus_valid=0, bus_state=0.
- Conflict: src_out=(1<<3)|(1<<16) -> bus_out keeps its previous value, bus_state=2, conflict=1. Then valid single drive of R3=7 -> bus_out=7 and conflict still 1. Then err_clr=1 -> conflict=0.
- Simultaneous: err_clr=1 on the same edge as a conflict -> conflict remains 1.
- Freeze: bus_en=0 with src_out=1<<17, LO=0xFFFF0000 -> outputs unchanged. Set bus_en=1 -> bus_out=0xFFFF0000 after one edge.
- Async reset mid-drive: assert clr between clock edges while in DRIVE -> outputs reset immediately without waiting for clk.
